ahb3lite_sram_slave: RTL and testbench
======================================

// Module: ahb3lite_sram_slave
// PURPOSE
//  AHB3-Lite responder: word-addressed SRAM slave answering the ahb3lite_pkg master FSM.
//  Decodes address phases, inserts programmable wait states, returns read data.
//  Signals ERROR with the two-cycle AHB error response. Sits behind the decoder/mux on the same HCLK.
// PARAMETERS
//  ADDR_WIDTH   32   HADDR width
//  DATA_WIDTH   32   HWDATA/HRDATA width (fixed 32; WORD = 3'b010)
//  MEM_DEPTH    256  number of 32-bit words; valid byte addresses 0 .. 4*MEM_DEPTH-1
//  WAIT_STATES  0    HREADYOUT-low cycles inserted per accepted OKAY transfer (0..15)
// PORTS
//  HCLK       in   1           system clock, all logic on rising edge
//  HRESETn    in   1           asynchronous active-low reset
//  HSEL       in   1           slave select from decoder
//  HADDR      in   ADDR_WIDTH  byte address
//  HWRITE     in   1           WRITE=1 / READ=0 (ahb3lite_pkg)
//  HSIZE      in   3           transfer size
//  HBURST     in   3           burst type; informational only, no address generation
//  HTRANS     in   2           HTRANS_state: IDLE/BUSY/NONSEQ/SEQ
//  HWDATA     in   DATA_WIDTH  write data, data phase
//  HREADY     in   1           bus HREADY (previous transfer complete)
//  HREADYOUT  out  1           slave ready / transfer done
//  HRDATA     out  DATA_WIDTH  read data, data phase
//  HRESP      out  1           HRESP_state encoding: OKAY=1'b1, ERROR=1'b0
// BEHAVIOUR
//  - Reset (async, any state): state=S_IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0,
//    wait counter=0, pending write dropped. Memory contents not reset.
//  - Accept: HSEL & HREADY & HTRANS in {NONSEQ,SEQ} at rising edge.
//    Register addr, write, size for the data phase.
//  - IDLE/BUSY with HSEL&HREADY: zero-wait OKAY response next cycle; no memory access.
//  - Error check at accept: word index >= MEM_DEPTH, HADDR[1:0]!=0, or HSIZE!=WORD -> ERROR.
//  - FSM states:
//    S_IDLE: HREADYOUT=1, HRESP=OKAY. On accept:
//      error -> S_ERR1; WAIT_STATES>0 -> S_WAIT; else -> S_DATA.
//    S_WAIT: HREADYOUT=0, HRESP=OKAY; counter runs 0..WAIT_STATES-1, then -> S_DATA.
//    S_DATA: HREADYOUT=1, HRESP=OKAY.
//      Write: mem[addr_q] <= HWDATA at this edge. Read: HRDATA = mem[addr_q].
//      Next state from new accept (back-to-back pipelining), else S_IDLE.
//    S_ERR1: HREADYOUT=0, HRESP=ERROR; no memory access; -> S_ERR2.
//    S_ERR2: HREADYOUT=1, HRESP=ERROR. Accept here is evaluated as in S_IDLE.
//  - Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; error = 2 cycles.
//  - HRDATA = 0 outside a read S_DATA cycle.
//  - Read-after-write, same address, back-to-back: read returns the newly written data.
//    The write commits at the edge ending its data phase, before the read data phase.
//  - Master cancels burst after ERROR (IDLE in S_ERR2): honoured, -> S_IDLE.
//  - HSEL low or HREADY low: no accept; an in-progress data phase still completes.
//  - Word index computed from HADDR[ADDR_WIDTH-1:2]; upper bits included in the range check (no aliasing).
// CONFIGURATION
//  AHB3LITE_SUBWORD_EN:
//   defined:
//    - HSIZE BYTE(000) and HALF(001) accepted when size-aligned (HALF needs HADDR[0]=0).
//    - Writes update only the addressed byte lanes (little-endian).
//    - Reads return the full word.
//    - WORD alignment rule unchanged; HSIZE>WORD -> ERROR.
//   undefined:
//    - any HSIZE!=WORD -> ERROR.
// TESTING
//  1. Reset asserted mid S_WAIT (WAIT_STATES=3) -> HREADYOUT=1, HRESP=OKAY, HRDATA=0 same cycle.
//     The dropped write address still reads its old value afterwards.
//  2. WAIT_STATES=0: NONSEQ write 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back
//     -> read data phase HRDATA=0xDEADBEEF, HREADYOUT=1 throughout.
//  3. WAIT_STATES=2: INCR4 read @0x00..0x0C -> each beat 2 cycles HREADYOUT=0 then 1.
//     Data matches preloaded words; HRESP=OKAY.
//  4. Read @4*MEM_DEPTH (0x400 default) -> cycle1 HREADYOUT=0/HRESP=0, cycle2 HREADYOUT=1/HRESP=0.
//     Then IDLE -> HRESP=1.
//  5. HSIZE=BYTE write @0x21 data 0x0000AB00, SUBWORD_EN off -> ERROR, word 0x20 unchanged.
//     With SUBWORD_EN on -> word 0x20 = old with byte1=0xAB.
//  6. HTRANS=BUSY inside INCR burst, HSEL=1 -> zero-wait OKAY, memory untouched.
//     Following SEQ completes normally.

Source files
------------

// File: rtl/ahb3lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb3lite_sram_slave
// Description : AHB3-Lite word-addressed SRAM responder with programmable wait
//               states and two-cycle ERROR response. Optional sub-word access
//               is enabled by defining AHB3LITE_SUBWORD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb3lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HRESP
);

  localparam int                  c_aw        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]          c_size_word = 3'b010;
  localparam logic [3:0]          c_wait_last = 4'(WAIT_STATES - 1);
  localparam logic [ADDR_WIDTH-3:0] c_depth   = (ADDR_WIDTH-2)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  state_t                r_state;
  logic [c_aw-1:0]       r_addr;
  logic                  r_write;
  logic [3:0]            r_be;
  logic [3:0]            r_wcnt;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;

  logic                  w_accept;
  logic [c_aw-1:0]       w_idx;
  logic                  w_range_err;
  logic                  w_size_err;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd_fwd;
  logic                  w_unused;

  assign w_accept    = HSEL & HREADY & HTRANS[1];
  assign w_idx       = HADDR[c_aw+1:2];
  // Full upper address participates so out-of-range addresses never alias.
  assign w_range_err = (HADDR[ADDR_WIDTH-1:2] >= c_depth);
  assign w_unused    = ^HBURST;

`ifdef AHB3LITE_SUBWORD_EN
  always_comb begin
    w_size_err = 1'b0;
    w_be       = 4'b0000;
    case (HSIZE)
      3'b000: w_be = 4'b0001 << HADDR[1:0];
      3'b001: begin
        w_be       = HADDR[1] ? 4'b1100 : 4'b0011;
        w_size_err = HADDR[0];
      end
      3'b010: begin
        w_be       = 4'b1111;
        w_size_err = |HADDR[1:0];
      end
      default: w_size_err = 1'b1;
    endcase
  end
`else
  assign w_be       = 4'b1111;
  assign w_size_err = (HSIZE != c_size_word) | (|HADDR[1:0]);
`endif

  always_comb begin
    w_wr_word = r_mem[r_addr];
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // A read accepted while the previous write commits must see the new word.
  assign w_rd_fwd = (r_state == S_DATA && r_write && r_addr == w_idx) ? w_wr_word : r_mem[w_idx];

  always_ff @(posedge HCLK) begin
    if (r_state == S_DATA && r_write) r_mem[r_addr] <= w_wr_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_be        <= 4'b0000;
      r_wcnt      <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b1;
      r_hrdata    <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_wcnt == c_wait_last) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            r_hrdata    <= r_write ? '0 : r_mem[r_addr];
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
        end
        default: begin
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
          r_hrdata    <= '0;
          if (w_accept) begin
            r_addr  <= w_idx;
            r_write <= HWRITE;
            r_be    <= w_be;
            if (w_range_err | w_size_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_hreadyout <= 1'b0;
              r_wcnt      <= 4'd0;
            end else begin
              r_state <= S_DATA;
              if (!HWRITE) r_hrdata <= w_rd_fwd;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb3lite_sram_slave
// Description : Table-driven bench for ahb3lite_sram_slave; three instances
//               with 0, 2 and 3 wait states share one pipelined master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] c_idle = 2'b00, c_busy = 2'b01, c_ns = 2'b10, c_seq = 2'b11;
  localparam logic [2:0] c_b = 3'b000, c_w = 3'b010, c_d = 3'b011;
`ifdef AHB3LITE_SUBWORD_EN
  localparam logic c_sub = 1'b1;
`else
  localparam logic c_sub = 1'b0;
`endif

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [2:0]  rdy, rsp;
  logic [31:0] rd [3];
  int          dsel = 0;
  int          c_wait [3] = '{0, 2, 3};
  vec_t        vt [35];
  exp_t        sbq [$];
  int          n_checks = 0, n_errors = 0;

  wire         m_rdy = rdy[dsel];
  wire         m_rsp = rsp[dsel];
  wire [31:0]  m_rd  = rd[dsel];
  wire         hs0 = HSEL && (dsel == 0);
  wire         hs1 = HSEL && (dsel == 1);
  wire         hs2 = HSEL && (dsel == 2);

  always #5 clk = ~clk;

  ahb3lite_sram_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(hs0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRDATA(rd[0]), .HRESP(rsp[0]));
  ahb3lite_sram_slave #(.WAIT_STATES(2)) u_dut1 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(hs1), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRDATA(rd[1]), .HRESP(rsp[1]));
  ahb3lite_sram_slave #(.WAIT_STATES(3)) u_dut2 (
    .HCLK(clk), .HRESETn(HRESETn), .HSEL(hs2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(rdy[2]), .HREADYOUT(rdy[2]), .HRDATA(rd[2]), .HRESP(rsp[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic er,
                      input logic [31:0] rv);
    vt[i].trans = tr; vt[i].wr = wr; vt[i].size = sz; vt[i].addr = a;
    vt[i].wdata = wd; vt[i].err = er; vt[i].rdata = rv;
  endtask

  task automatic drive_addr(input int i);
    HSEL = 1'b1; HTRANS = vt[i].trans; HWRITE = vt[i].wr;
    HSIZE = vt[i].size; HADDR = vt[i].addr; HBURST = 3'b001;
  endtask

  task automatic drive_idle();
    HSEL = 1'b1; HTRANS = c_idle; HWRITE = 1'b0; HSIZE = c_w; HADDR = 32'h0; HBURST = 3'b000;
  endtask

  // Pipelined master: address phase of entry ai overlaps data phase of the previous one.
  task automatic run_seg(input int first, input int last);
    int ai, low, cyc;
    bit have, lowbad;
    exp_t e;
    logic [31:0] wd;
    ai = first; have = 0; low = 0; lowbad = 0; cyc = 0; wd = 32'h0;
    drive_addr(ai);
    while ((ai <= last || have) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (have && !m_rdy) begin
        low++;
        if (m_rsp !== !sbq[0].err) lowbad = 1;
      end
      if (m_rdy) begin
        if (have) begin
          e = sbq.pop_front();
          chk($sformatf("v%0d rdata", e.idx), m_rd, e.rdata);
          chk($sformatf("v%0d resp", e.idx), {31'd0, m_rsp}, {31'd0, !e.err});
          chk($sformatf("v%0d waits", e.idx), 32'(low), 32'(e.waits));
          chk($sformatf("v%0d resp_while_low", e.idx), {31'd0, lowbad}, 32'd0);
          have = 0;
        end
        if (ai <= last) begin
          e.idx = ai; e.err = vt[ai].err; e.rdata = vt[ai].rdata;
          e.waits = vt[ai].err ? 1 : (vt[ai].trans[1] ? c_wait[dsel] : 0);
          sbq.push_back(e);
          wd = vt[ai].wdata; ai++; have = 1; low = 0; lowbad = 0;
        end
      end
      @(posedge clk); #1;
      if (ai <= last) drive_addr(ai); else drive_idle();
      HWDATA = wd;
    end
    chk($sformatf("seg%0d drained", first), {31'd0, have}, 32'd0);
    sbq.delete();
  endtask

  initial begin
    // WAIT_STATES=0 instance
    setv( 0, c_ns,   1, c_w, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    setv( 1, c_ns,   0, c_w, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    setv( 2, c_ns,   1, c_w, 32'h00, 32'h11111111, 0, 32'h0);
    setv( 3, c_ns,   1, c_w, 32'h04, 32'h22222222, 0, 32'h0);
    setv( 4, c_ns,   1, c_w, 32'h08, 32'h33333333, 0, 32'h0);
    setv( 5, c_ns,   1, c_w, 32'h0C, 32'h44444444, 0, 32'h0);
    setv( 6, c_ns,   0, c_w, 32'h0C, 32'h0, 0, 32'h44444444);
    setv( 7, c_ns,   0, c_w, 32'h400, 32'h0, 1, 32'h0);
    setv( 8, c_idle, 0, c_w, 32'h0, 32'h0, 0, 32'h0);
    setv( 9, c_ns,   1, c_w, 32'h20, 32'h12345678, 0, 32'h0);
    setv(10, c_ns,   1, c_b, 32'h21, 32'h0000AB00, !c_sub, 32'h0);
    setv(11, c_ns,   0, c_w, 32'h20, 32'h0, 0, c_sub ? 32'h1234AB78 : 32'h12345678);
    setv(12, c_ns,   0, c_w, 32'h22, 32'h0, 1, 32'h0);
    setv(13, c_ns,   0, c_d, 32'h00, 32'h0, 1, 32'h0);
    setv(14, c_ns,   0, c_w, 32'h10000010, 32'h0, 1, 32'h0);
    setv(15, c_ns,   1, c_w, 32'h38, 32'h77777777, 0, 32'h0);
    setv(16, c_ns,   1, c_w, 32'h30, 32'hA5A5A5A5, 0, 32'h0);
    setv(17, c_busy, 1, c_w, 32'h38, 32'hBAD0BAD0, 0, 32'h0);
    setv(18, c_seq,  1, c_w, 32'h34, 32'h5A5A5A5A, 0, 32'h0);
    setv(19, c_ns,   0, c_w, 32'h30, 32'h0, 0, 32'hA5A5A5A5);
    setv(20, c_seq,  0, c_w, 32'h34, 32'h0, 0, 32'h5A5A5A5A);
    setv(21, c_seq,  0, c_w, 32'h38, 32'h0, 0, 32'h77777777);
    setv(22, c_ns,   0, c_w, 32'h04, 32'h0, 0, 32'h22222222);
    // WAIT_STATES=2 instance: preload, INCR4 read, read-after-write
    for (int i = 0; i < 4; i++) begin
      setv(23 + i, c_ns, 1, c_w, 32'(4 * i), 32'hA0000000 + 32'(i), 0, 32'h0);
      setv(27 + i, (i == 0) ? c_ns : c_seq, 0, c_w, 32'(4 * i), 32'h0, 0, 32'hA0000000 + 32'(i));
    end
    setv(31, c_ns,   1, c_w, 32'h10, 32'h55AA55AA, 0, 32'h0);
    setv(32, c_ns,   0, c_w, 32'h10, 32'h0, 0, 32'h55AA55AA);
    // WAIT_STATES=3 instance: reset during a wait-stated write
    setv(33, c_ns,   1, c_w, 32'h40, 32'hCAFEF00D, 0, 32'h0);
    setv(34, c_ns,   0, c_w, 32'h40, 32'h0, 0, 32'hCAFEF00D);

    HRESETn = 1'b0; HWDATA = 32'h0;
    drive_idle();
    HSEL = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d hreadyout", k), {31'd0, rdy[k]}, 32'd1);
      chk($sformatf("rst%0d hresp", k), {31'd0, rsp[k]}, 32'd1);
      chk($sformatf("rst%0d hrdata", k), rd[k], 32'h0);
    end
    @(posedge clk); #1;
    HRESETn = 1'b1;
    @(posedge clk); #1;

    dsel = 0; run_seg(0, 22);
    dsel = 1; run_seg(23, 32);
    dsel = 2; run_seg(33, 33);

    // Async reset while the second write to 0x40 sits in S_WAIT.
    HSEL = 1'b1; HTRANS = c_ns; HWRITE = 1'b1; HSIZE = c_w; HADDR = 32'h40;
    @(posedge clk); #1;
    HWDATA = 32'h0BADF00D;
    drive_idle();
    @(negedge clk);
    chk("midwait hreadyout", {31'd0, m_rdy}, 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("midrst hreadyout", {31'd0, m_rdy}, 32'd1);
    chk("midrst hresp", {31'd0, m_rsp}, 32'd1);
    chk("midrst hrdata", m_rd, 32'h0);
    @(posedge clk); #1;
    HRESETn = 1'b1;
    @(posedge clk); #1;
    run_seg(34, 34);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
